// File: rtl/metropolis_judge.sv
// metropolis_judge
//   Metropolis accept/reject stage for one replica node, time-multiplexed over
//   BASE_NUM bases. Each cycle the base selected by base_id may receive a move
//   proposal (judged from delta, prob and rnd), a replica-exchange load from a
//   neighbour, or a shift-load. Per-base total distance is kept with saturating
//   arithmetic, together with per-base accepted/judged move counters.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   base_id             base addressed this cycle (all per-base ports)
//   in_valid/in_kind    move proposal and its kind (0=THR 1=TWO 2=OR)
//   in_k_lt_l           K<L flag for or-opt moves
//   delta               signed distance change of the proposed move
//   prob, rnd           exp-unit probability and uniform random for the test
//   xchg_cmd            0=NONE 1=PREV 2=FOLW 3=reserved(NONE)
//   distance_shift      unconditional load of prev_data
//   prev_data/folw_data neighbour distances
//   out_data            dist[base_id], combinational
//   out_valid/out_com   registered decision (0=THR 1=TWO 2=OR0 3=OR1)
//   out_base            base of the registered decision
//   sat_flag            sticky flag: some distance update was clamped
//   stat_clr            clear all statistics counters
//   stat_sel            statistics read select
//   stat_acc/stat_trial registered counter read-back for stat_sel
module metropolis_judge #(
  parameter int ID       = 0,
  parameter int BASE_NUM = 4,
  parameter int DATA_W   = 27,
  parameter int DELTA_W  = 25,
  parameter int PROB_W   = 23,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(BASE_NUM)-1:0] base_id,
  input  logic                        in_valid,
  input  logic [1:0]                  in_kind,
  input  logic                        in_k_lt_l,
  input  logic signed [DELTA_W-1:0]   delta,
  input  logic signed [PROB_W+3:0]    prob,
  input  logic [PROB_W-1:0]           rnd,
  input  logic [1:0]                  xchg_cmd,
  input  logic                        distance_shift,
  input  logic [DATA_W-1:0]           prev_data,
  input  logic [DATA_W-1:0]           folw_data,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  output logic [1:0]                  out_com,
  output logic [$clog2(BASE_NUM)-1:0] out_base,
  output logic                        sat_flag,
  input  logic                        stat_clr,
  input  logic [$clog2(BASE_NUM)-1:0] stat_sel,
  output logic [CNT_W-1:0]            stat_acc,
  output logic [CNT_W-1:0]            stat_trial
);

  localparam int BW = $clog2(BASE_NUM);

  typedef enum logic [1:0] {KIND_THR, KIND_TWO, KIND_OR, KIND_RSVD} kind_e;
  typedef enum logic [1:0] {COM_THR, COM_TWO, COM_OR0, COM_OR1} com_e;
  typedef enum logic [1:0] {XCHG_NONE, XCHG_PREV, XCHG_FOLW, XCHG_RSVD} xchg_e;

  // Time-multiplexing needs at least two bases; ID is only informational.
  if (BASE_NUM < 2 || ID < 0) begin : g_param_check
    $error("metropolis_judge: BASE_NUM must be >= 2 and ID non-negative");
  end

  logic [DATA_W-1:0] dist_q  [BASE_NUM];
  logic [DATA_W-1:0] dist_d  [BASE_NUM];
  logic [CNT_W-1:0]  acc_q   [BASE_NUM];
  logic [CNT_W-1:0]  acc_d   [BASE_NUM];
  logic [CNT_W-1:0]  trial_q [BASE_NUM];
  logic [CNT_W-1:0]  trial_d [BASE_NUM];

  logic          out_valid_q, out_valid_d;
  com_e          out_com_q, out_com_d;
  logic [BW-1:0] out_base_q, out_base_d;
  logic          sat_flag_q, sat_flag_d;
  logic [CNT_W-1:0] stat_acc_q, stat_acc_d;
  logic [CNT_W-1:0] stat_trial_q, stat_trial_d;

  logic                     xchg_prev, xchg_folw, exch_busy;
  logic                     judge, accept;
  logic                     delta_nonpos, prob_wins;
  logic [DATA_W-1:0]        cur_dist;
  logic signed [DATA_W+1:0] sum;
  logic [DATA_W-1:0]        sat_dist;
  logic                     clamp;

  // Move decision and saturating distance update for the addressed base.
  always_comb begin
    xchg_prev    = (xchg_cmd == XCHG_PREV);
    xchg_folw    = (xchg_cmd == XCHG_FOLW);
    exch_busy    = xchg_prev || xchg_folw || distance_shift;
    judge        = in_valid && (in_kind != KIND_THR) && !exch_busy;
    delta_nonpos = delta[DELTA_W-1] || (delta == '0);
    // rnd is unsigned; zero-extend it into prob's signed width before comparing.
    prob_wins    = prob > $signed({4'b0000, rnd});
    accept       = judge && (delta_nonpos || prob_wins);

    cur_dist = '0;
    for (int i = 0; i < BASE_NUM; i++) begin
      if (base_id == BW'(i)) cur_dist = dist_q[i];
    end

    // Two guard bits: the top one catches underflow, the next one overflow.
    sum   = $signed({2'b00, cur_dist}) +
            $signed({{(DATA_W + 2 - DELTA_W){delta[DELTA_W-1]}}, delta});
    clamp = 1'b0;
    if (sum[DATA_W+1]) begin
      sat_dist = '0;
      clamp    = 1'b1;
    end else if (sum[DATA_W]) begin
      sat_dist = '1;
      clamp    = 1'b1;
    end else begin
      sat_dist = sum[DATA_W-1:0];
    end
  end

  // Next-state for the per-base distance and statistics arrays.
  always_comb begin
    for (int i = 0; i < BASE_NUM; i++) begin
      dist_d[i]  = dist_q[i];
      acc_d[i]   = acc_q[i];
      trial_d[i] = trial_q[i];
      if (base_id == BW'(i)) begin
        if (distance_shift || xchg_prev) dist_d[i] = prev_data;
        else if (xchg_folw)              dist_d[i] = folw_data;
        else if (accept)                 dist_d[i] = sat_dist;
        if (judge && (trial_q[i] != '1)) trial_d[i] = trial_q[i] + 1'b1;
        if (accept && (acc_q[i] != '1))  acc_d[i]   = acc_q[i] + 1'b1;
      end
      if (stat_clr) begin
        acc_d[i]   = '0;
        trial_d[i] = '0;
      end
    end

    stat_acc_d   = '0;
    stat_trial_d = '0;
    for (int i = 0; i < BASE_NUM; i++) begin
      if (stat_sel == BW'(i)) begin
        stat_acc_d   = acc_q[i];
        stat_trial_d = trial_q[i];
      end
    end

    out_valid_d = in_valid;
    out_base_d  = base_id;
    out_com_d   = COM_THR;
    if (accept && in_kind == KIND_TWO)     out_com_d = COM_TWO;
    else if (accept && in_kind == KIND_OR) out_com_d = in_k_lt_l ? COM_OR0 : COM_OR1;
    sat_flag_d = sat_flag_q || (accept && clamp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BASE_NUM; i++) begin
        dist_q[i]  <= '0;
        acc_q[i]   <= '0;
        trial_q[i] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_com_q    <= COM_THR;
      out_base_q   <= '0;
      sat_flag_q   <= 1'b0;
      stat_acc_q   <= '0;
      stat_trial_q <= '0;
    end else begin
      for (int i = 0; i < BASE_NUM; i++) begin
        dist_q[i]  <= dist_d[i];
        acc_q[i]   <= acc_d[i];
        trial_q[i] <= trial_d[i];
      end
      out_valid_q  <= out_valid_d;
      out_com_q    <= out_com_d;
      out_base_q   <= out_base_d;
      sat_flag_q   <= sat_flag_d;
      stat_acc_q   <= stat_acc_d;
      stat_trial_q <= stat_trial_d;
    end
  end

  assign out_data   = cur_dist;
  assign out_valid  = out_valid_q;
  assign out_com    = out_com_q;
  assign out_base   = out_base_q;
  assign sat_flag   = sat_flag_q;
  assign stat_acc   = stat_acc_q;
  assign stat_trial = stat_trial_q;

endmodule

// File: tb/tb_metropolis_judge.sv
// tb_metropolis_judge
//   Drives metropolis_judge (4 bases, 27-bit distances, 4-bit counters) with
//   directed scenarios followed by random traffic, comparing every cycle against
//   a behavioural model kept in integer arithmetic.
module tb_metropolis_judge;

  localparam int BASE_NUM = 4;
  localparam int DATA_W   = 27;
  localparam int DELTA_W  = 25;
  localparam int PROB_W   = 23;
  localparam int CNT_W    = 4;
  localparam longint DMAX = (longint'(1) << DATA_W) - 1;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [1:0]                base_id;
  logic                      in_valid;
  logic [1:0]                in_kind;
  logic                      in_k_lt_l;
  logic signed [DELTA_W-1:0] delta;
  logic signed [PROB_W+3:0]  prob;
  logic [PROB_W-1:0]         rnd;
  logic [1:0]                xchg_cmd;
  logic                      distance_shift;
  logic [DATA_W-1:0]         prev_data;
  logic [DATA_W-1:0]         folw_data;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic [1:0]                out_com;
  logic [1:0]                out_base;
  logic                      sat_flag;
  logic                      stat_clr;
  logic [1:0]                stat_sel;
  logic [CNT_W-1:0]          stat_acc;
  logic [CNT_W-1:0]          stat_trial;

  // Clock generation
  always #5 clk = ~clk;

  metropolis_judge #(
    .ID(0), .BASE_NUM(BASE_NUM), .DATA_W(DATA_W), .DELTA_W(DELTA_W),
    .PROB_W(PROB_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .base_id(base_id), .in_valid(in_valid),
    .in_kind(in_kind), .in_k_lt_l(in_k_lt_l), .delta(delta), .prob(prob),
    .rnd(rnd), .xchg_cmd(xchg_cmd), .distance_shift(distance_shift),
    .prev_data(prev_data), .folw_data(folw_data), .out_data(out_data),
    .out_valid(out_valid), .out_com(out_com), .out_base(out_base),
    .sat_flag(sat_flag), .stat_clr(stat_clr), .stat_sel(stat_sel),
    .stat_acc(stat_acc), .stat_trial(stat_trial)
  );

  // Reference state: per-base distance and counters, sticky clamp flag
  longint mDist  [BASE_NUM];
  int     mAcc   [BASE_NUM];
  int     mTrial [BASE_NUM];
  bit     mSat;
  int     numChecks = 0;
  int     numErrors = 0;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    numChecks++;
    if (obs != exp) begin
      numErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < BASE_NUM; i++) begin
      mDist[i]  = 0;
      mAcc[i]   = 0;
      mTrial[i] = 0;
    end
    mSat = 1'b0;
  endtask

  task automatic idleInputs();
    base_id = 0; in_valid = 0; in_kind = 0; in_k_lt_l = 0; delta = 0;
    prob = 0; rnd = 0; xchg_cmd = 0; distance_shift = 0; prev_data = 0;
    folw_data = 0; stat_clr = 0; stat_sel = 0;
  endtask

  // Reset with a live proposal on the inputs: nothing may leak through
  task automatic resetDut();
    reset = 1'b1;
    idleInputs();
    in_valid = 1'b1; in_kind = 2'd1; delta = -25'sd3; base_id = 2'd1;
    @(posedge clk); #1;
    modelReset();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_com", out_com, 0);
    checkOutput("rst_out_base", out_base, 0);
    checkOutput("rst_sat_flag", sat_flag, 0);
    checkOutput("rst_stat_acc", stat_acc, 0);
    checkOutput("rst_stat_trial", stat_trial, 0);
    reset = 1'b0;
    idleInputs();
  endtask

  // One cycle: drive inputs, check the combinational read, predict the edge,
  // then check every registered output after the edge.
  task automatic applyStimulus(input int base, input bit valid, input int kind,
                               input bit klt, input longint dlt, input longint prb,
                               input longint rn, input int xc, input bit shift,
                               input longint prv, input longint flw, input bit clr,
                               input int sel);
    bit     judge, accept;
    longint s;
    int     eCom, eAcc, eTrial;
    base_id = 2'(base); in_valid = valid; in_kind = 2'(kind); in_k_lt_l = klt;
    delta = DELTA_W'(dlt); prob = 27'(prb); rnd = PROB_W'(rn);
    xchg_cmd = 2'(xc); distance_shift = shift; prev_data = DATA_W'(prv);
    folw_data = DATA_W'(flw); stat_clr = clr; stat_sel = 2'(sel);
    #1;
    checkOutput("out_data", out_data, mDist[base]);

    judge  = valid && kind != 0 && (xc == 0 || xc == 3) && !shift;
    accept = judge && (dlt <= 0 || prb > rn);
    eAcc   = mAcc[sel];
    eTrial = mTrial[sel];
    eCom   = 0;
    if (accept && kind == 1) eCom = 1;
    if (accept && kind == 2) eCom = klt ? 2 : 3;

    if (shift || xc == 1) mDist[base] = prv;
    else if (xc == 2)     mDist[base] = flw;
    else if (accept) begin
      s = mDist[base] + dlt;
      if (s < 0)         begin s = 0;    mSat = 1'b1; end
      else if (s > DMAX) begin s = DMAX; mSat = 1'b1; end
      mDist[base] = s;
    end
    if (clr) begin
      for (int i = 0; i < BASE_NUM; i++) begin
        mAcc[i] = 0; mTrial[i] = 0;
      end
    end else begin
      if (judge)  mTrial[base] = (mTrial[base] < CMAX) ? mTrial[base] + 1 : CMAX;
      if (accept) mAcc[base]   = (mAcc[base] < CMAX) ? mAcc[base] + 1 : CMAX;
    end

    @(posedge clk); #1;
    checkOutput("out_valid", out_valid, valid);
    checkOutput("out_com", out_com, eCom);
    checkOutput("out_base", out_base, base);
    checkOutput("sat_flag", sat_flag, mSat);
    checkOutput("stat_acc", stat_acc, eAcc);
    checkOutput("stat_trial", stat_trial, eTrial);
  endtask

  // Directed scenarios, a mid-run reset, then random traffic
  initial begin
    logic signed [DELTA_W-1:0] rDelta;
    logic signed [PROB_W+3:0]  rProb;
    longint dv, pv, rv, prv, flw;
    int     xc;

    reset = 1'b1;
    idleInputs();
    modelReset();
    @(posedge clk); #1;
    resetDut();

    // Basic accept of a downhill 2-opt move on base 2
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 1, 100, 0, 0, 2);
    applyStimulus(2, 1, 1, 0, -5, 0, 0, 0, 0, 0, 0, 0, 2);
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    // Uphill move: prob just above / equal to rnd
    applyStimulus(2, 1, 1, 0, 8, 1000, 999, 0, 0, 0, 0, 0, 2);
    applyStimulus(2, 1, 2, 1, 8, 1000, 1000, 0, 0, 0, 0, 0, 2);
    applyStimulus(2, 1, 2, 0, 0, -7, 5, 0, 0, 0, 0, 0, 2);
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    // Saturation at both ends
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, -10, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 1, DMAX - 1, 0, 0, 3);
    applyStimulus(3, 1, 1, 0, 5, 100, 0, 0, 0, 0, 0, 0, 3);
    applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Exchange wins over a concurrent move; reserved command behaves as NONE
    applyStimulus(1, 1, 2, 1, -3, 0, 0, 2, 0, 55, 777, 0, 1);
    applyStimulus(1, 1, 2, 1, -3, 0, 0, 1, 0, 600, 777, 0, 1);
    applyStimulus(1, 1, 2, 0, -3, 0, 0, 3, 0, 555, 777, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Counter saturation, then clear colliding with an accept
    resetDut();
    for (int i = 0; i < 20; i++)
      applyStimulus(1, 1, 1, 0, -1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 1, 0, -1, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Interleaved bases with distinct deltas
    for (int b = 0; b < BASE_NUM; b++)
      applyStimulus(b, 0, 0, 0, 0, 0, 0, 0, 1, 1000 * (b + 1), 0, 0, b);
    for (int i = 0; i < 16; i++)
      applyStimulus(i % 4, 1, 1 + (i % 2), i[0], -(i + 1) * 3, 0, 0, 0, 0, 0, 0, 0, (i + 1) % 4);

    // Random traffic with an occasional mid-run reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) resetDut();
      rDelta = DELTA_W'($urandom);
      dv = rDelta;
      if ($urandom_range(0, 1) == 0) dv = longint'($urandom_range(0, 400)) - 200;
      rProb = 27'($urandom);
      pv = rProb;
      rv = $urandom_range(0, (1 << PROB_W) - 1);
      if ($urandom_range(0, 1) == 0) begin
        pv = $urandom_range(0, 1 << PROB_W);
        rv = pv + longint'($urandom_range(0, 2)) - 1;
        if (rv < 0) rv = 0;
        if (rv > (1 << PROB_W) - 1) rv = (1 << PROB_W) - 1;
      end
      prv = longint'($urandom) & DMAX;
      flw = longint'($urandom) & DMAX;
      if ($urandom_range(0, 3) == 0) prv = $urandom_range(0, 50);
      if ($urandom_range(0, 3) == 0) flw = DMAX - $urandom_range(0, 50);
      xc = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 3);
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 9) < 8,
                    $urandom_range(0, 2), $urandom_range(0, 1), dv, pv, rv, xc,
                    $urandom_range(0, 19) == 0, prv, flw,
                    $urandom_range(0, 39) == 0, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
